// File: rtl/matrix_mul_pkg.sv
// Shared types and constants for the 2x2-tiled matrix multiply controller.
// Header word layout is [M1|N1|M2|N2], with M1 in the most significant field.
package matrix_mul_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR, CHECK, LOAD, MAC_START, MAC_WAIT, ACC, WB, NEXT, DONE, ERR
  } state_e;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_DIM_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_BAD_SIZE     = 2'd2;
  localparam logic [1:0] ERR_MAC_TMO      = 2'd3;

  localparam int HDR_BASE = 0;
  localparam int A_BASE   = 2;

  localparam int FLD_M1 = 3;
  localparam int FLD_N1 = 2;
  localparam int FLD_M2 = 1;
  localparam int FLD_N2 = 0;

  localparam int HDR_MAX_W = 64;

  // Field pos counts from the LSB end in units of dim_w bits.
  function automatic logic [HDR_MAX_W-1:0] hdr_field(input logic [HDR_MAX_W-1:0] word,
                                                     input int dim_w, input int pos);
    logic [HDR_MAX_W-1:0] mask;
    mask = (HDR_MAX_W'(1) << dim_w) - HDR_MAX_W'(1);
    return (word >> (pos * dim_w)) & mask;
  endfunction

endpackage

// File: rtl/matrix_tile_addr_gen.sv
// Maps a tile element index plus block counters to a RAM address and an in-range flag.
// idx[2] selects B (load only), idx[1] is the row within the tile, idx[0] the column.
module matrix_tile_addr_gen #(
  parameter int DIM_W = 8,
  parameter int XW    = 18,
  parameter int AW    = 9
) (
  input  logic             wb_i,
  input  logic [2:0]       idx_i,
  input  logic [DIM_W-1:0] i_i,
  input  logic [DIM_W-1:0] j_i,
  input  logic [DIM_W-1:0] k_i,
  input  logic [DIM_W-1:0] m1_i,
  input  logic [DIM_W-1:0] n1_i,
  input  logic [DIM_W-1:0] n2_i,
  input  logic [XW-1:0]    a_row_i,
  input  logic [XW-1:0]    b_row_i,
  input  logic [XW-1:0]    c_row_i,
  output logic [AW-1:0]    addr_o,
  output logic             in_range_o
);

  logic             r, c;
  logic [DIM_W:0]   row, col, rows, cols;
  logic [XW-1:0]    base, stride;

  assign r = idx_i[1];
  assign c = idx_i[0];

  always_comb begin
    row    = {i_i, r};
    col    = {k_i, c};
    rows   = {1'b0, m1_i};
    cols   = {1'b0, n1_i};
    base   = a_row_i;
    stride = XW'(n1_i);
    if (wb_i) begin
      col    = {j_i, c};
      cols   = {1'b0, n2_i};
      base   = c_row_i;
      stride = XW'(n2_i);
    end else if (idx_i[2]) begin
      // B rows are counted against N1, which CHECK has proven equal to M2.
      row    = {k_i, r};
      col    = {j_i, c};
      rows   = {1'b0, n1_i};
      cols   = {1'b0, n2_i};
      base   = b_row_i;
      stride = XW'(n2_i);
    end
  end

  assign in_range_o = (row < rows) && (col < cols);
  assign addr_o     = AW'(base + (r ? stride : '0) + XW'(col));

endmodule

// File: rtl/matrix_tile_mul_ctrl.sv
// Block matrix multiply controller: tiles A and B into 2x2 blocks, drives an external
// 2x2 MAC, accumulates over k and writes each finished C block back to the RAM.
module matrix_tile_mul_ctrl
  import matrix_mul_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RAM_D   = 512,
  parameter int RAM_AW  = $clog2(RAM_D),
  parameter int DIM_W   = DATA_W / 4,
  parameter int MAC_TMO = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              start_mac,
  input  logic              done_mac,
  output logic [DATA_W-1:0] a_11, a_12, a_21, a_22,
  output logic [DATA_W-1:0] b_11, b_12, b_21, b_22,
  input  logic [DATA_W-1:0] c_11, c_12, c_21, c_22,
  output logic [3:0]        dbg_state
);

  localparam int XW    = 2 * DIM_W + 2;
  localparam int LW    = DIM_W + 2;
  localparam int TMO_W = $clog2(MAC_TMO) + 1;

  state_e              state_q, state_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [3:0]          f_q;
  logic [DIM_W-1:0]    m1_q, n1_q, m2_q, n2_q, i_q, j_q, k_q;
  logic [XW-1:0]       b_base_q, c_base_q, c_end_q, a_row_q, b_row_q, c_row_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                inr_q;
  logic [DATA_W-1:0]   a_q [4];
  logic [DATA_W-1:0]   b_q [4];
  logic [DATA_W-1:0]   acc_q [4];

  logic [DIM_W-1:0]    h_m1, h_n1, h_m2, h_n2;
  logic [XW-1:0]       h_b_base, h_c_base, h_c_end;
  logic                k_last, j_last, i_last;
  logic                gen_wb, gen_inr, load_issue;
  logic [2:0]          gen_idx, cap_idx;
  logic [RAM_AW-1:0]   gen_addr;
  logic [DATA_W-1:0]   cap_val;

  assign h_m1 = DIM_W'(hdr_field(HDR_MAX_W'(ram_r_data), DIM_W, FLD_M1));
  assign h_n1 = DIM_W'(hdr_field(HDR_MAX_W'(ram_r_data), DIM_W, FLD_N1));
  assign h_m2 = DIM_W'(hdr_field(HDR_MAX_W'(ram_r_data), DIM_W, FLD_M2));
  assign h_n2 = DIM_W'(hdr_field(HDR_MAX_W'(ram_r_data), DIM_W, FLD_N2));

  assign h_b_base = XW'(A_BASE) + XW'(h_m1) * XW'(h_n1);
  assign h_c_base = h_b_base + XW'(h_m2) * XW'(h_n2);
  assign h_c_end  = h_c_base + XW'(h_m1) * XW'(h_n2);

  // "Last block" tests as 2*idx+2 >= dim, i.e. idx == ceil(dim/2)-1.
  assign k_last = ({1'b0, k_q, 1'b0} + LW'(2)) >= {2'b00, n1_q};
  assign j_last = ({1'b0, j_q, 1'b0} + LW'(2)) >= {2'b00, n2_q};
  assign i_last = ({1'b0, i_q, 1'b0} + LW'(2)) >= {2'b00, m1_q};

  assign gen_wb     = (state_q == WB);
  assign gen_idx    = gen_wb ? {1'b0, f_q[1:0]} : f_q[2:0];
  assign load_issue = (state_q == LOAD) && !f_q[3];
  assign cap_idx    = 3'(f_q - 4'd1);
  assign cap_val    = inr_q ? ram_r_data : '0;

  matrix_tile_addr_gen #(.DIM_W(DIM_W), .XW(XW), .AW(RAM_AW)) u_addr_gen (
    .wb_i      (gen_wb),
    .idx_i     (gen_idx),
    .i_i       (i_q),
    .j_i       (j_q),
    .k_i       (k_q),
    .m1_i      (m1_q),
    .n1_i      (n1_q),
    .n2_i      (n2_q),
    .a_row_i   (a_row_q),
    .b_row_i   (b_row_q),
    .c_row_i   (c_row_q),
    .addr_o    (gen_addr),
    .in_range_o(gen_inr)
  );

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign start_mac  = (state_q == MAC_START);
  assign err_code   = err_code_q;
  assign dbg_state  = state_q;
  assign ram_addr   = ((load_issue || gen_wb) && gen_inr) ? gen_addr : '0;
  assign ram_we     = gen_wb && gen_inr;
  assign ram_w_data = gen_wb ? acc_q[f_q[1:0]] : '0;

  assign a_11 = a_q[0];
  assign a_12 = a_q[1];
  assign a_21 = a_q[2];
  assign a_22 = a_q[3];
  assign b_11 = b_q[0];
  assign b_12 = b_q[1];
  assign b_21 = b_q[2];
  assign b_22 = b_q[3];

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = HDR;
        err_code_d = ERR_NONE;
      end
      HDR:   state_d = CHECK;
      CHECK: begin
        if ((m1_q == '0) || (n1_q == '0) || (m2_q == '0) || (n2_q == '0) ||
            (c_end_q > XW'(RAM_D))) begin
          state_d    = ERR;
          err_code_d = ERR_BAD_SIZE;
        end else if (n1_q != m2_q) begin
          state_d    = ERR;
          err_code_d = ERR_DIM_MISMATCH;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD:      if (f_q == 4'd8) state_d = MAC_START;
      MAC_START: state_d = MAC_WAIT;
      MAC_WAIT: begin
        if (done_mac) begin
          state_d = ACC;
        end else if (tmo_q == TMO_W'(MAC_TMO - 2)) begin
          state_d    = ERR;
          err_code_d = ERR_MAC_TMO;
        end
      end
      ACC:  state_d = k_last ? WB : LOAD;
      WB:   if (f_q == 4'd3) state_d = NEXT;
      NEXT: state_d = (i_last && j_last) ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0; tmo_q <= '0; inr_q <= 1'b0;
      m1_q <= '0; n1_q <= '0; m2_q <= '0; n2_q <= '0;
      i_q <= '0; j_q <= '0; k_q <= '0;
      b_base_q <= '0; c_base_q <= '0; c_end_q <= '0;
      a_row_q <= '0; b_row_q <= '0; c_row_q <= '0;
      for (int x = 0; x < 4; x++) begin
        a_q[x] <= '0; b_q[x] <= '0; acc_q[x] <= '0;
      end
    end else begin
      inr_q <= gen_inr;
      if ((state_q == LOAD || state_q == WB) && state_d == state_q) f_q <= f_q + 4'd1;
      else f_q <= '0;
      case (state_q)
        HDR: begin
          m1_q <= h_m1; n1_q <= h_n1; m2_q <= h_m2; n2_q <= h_n2;
          b_base_q <= h_b_base; c_base_q <= h_c_base; c_end_q <= h_c_end;
        end
        CHECK: begin
          i_q <= '0; j_q <= '0; k_q <= '0;
          a_row_q <= XW'(A_BASE); b_row_q <= b_base_q; c_row_q <= c_base_q;
          for (int x = 0; x < 4; x++) acc_q[x] <= '0;
        end
        // Capture trails the address by one cycle to match the RAM read latency.
        LOAD: if (f_q != 4'd0) begin
          if (cap_idx[2]) b_q[cap_idx[1:0]] <= cap_val;
          else            a_q[cap_idx[1:0]] <= cap_val;
        end
        MAC_START: tmo_q <= '0;
        // The MAC result is only guaranteed on the done_mac cycle, so sum it here.
        MAC_WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (done_mac) begin
            acc_q[0] <= acc_q[0] + c_11;
            acc_q[1] <= acc_q[1] + c_12;
            acc_q[2] <= acc_q[2] + c_21;
            acc_q[3] <= acc_q[3] + c_22;
          end
        end
        ACC: if (!k_last) begin
          k_q     <= k_q + DIM_W'(1);
          b_row_q <= b_row_q + (XW'(n2_q) << 1);
        end
        WB: if (f_q == 4'd3) begin
          for (int x = 0; x < 4; x++) acc_q[x] <= '0;
        end
        NEXT: begin
          k_q     <= '0;
          b_row_q <= b_base_q;
          if (j_last) begin
            j_q     <= '0;
            i_q     <= i_q + DIM_W'(1);
            a_row_q <= a_row_q + (XW'(n1_q) << 1);
            c_row_q <= c_row_q + (XW'(n2_q) << 1);
          end else begin
            j_q <= j_q + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_tile_mul_ctrl.sv
// Bench for matrix_tile_mul_ctrl: RAM and 2x2 MAC models, scoreboard of expected C writes
// built from a plain matrix-product reference before each run.
module tb_matrix_tile_mul_ctrl;
  import matrix_mul_pkg::*;

  localparam int DATA_W  = 32;
  localparam int RAM_D   = 512;
  localparam int RAM_AW  = 9;
  localparam int MAC_TMO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, err, ram_we, start_mac;
  logic              done_mac = 1'b0;
  logic [1:0]        err_code;
  logic [3:0]        dbg_state;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_w_data, ram_r_data;
  logic [DATA_W-1:0] a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22;
  logic [DATA_W-1:0] c_11, c_12, c_21, c_22;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  matrix_tile_mul_ctrl #(.DATA_W(DATA_W), .RAM_D(RAM_D), .MAC_TMO(MAC_TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .ram_addr(ram_addr), .ram_we(ram_we), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data), .start_mac(start_mac), .done_mac(done_mac),
    .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
    .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
    .c_11(c_11), .c_12(c_12), .c_21(c_21), .c_22(c_22),
    .dbg_state(dbg_state)
  );

  // ---------------- RAM and MAC models ----------------
  logic [DATA_W-1:0] mem [RAM_D];
  always @(posedge clk) begin
    ram_r_data <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_w_data;
  end

  logic              mac_en = 1'b1;
  logic              mac_pend = 1'b0;
  logic [2:0]        mac_lat;
  logic [DATA_W-1:0] prod [4];
  always @(posedge clk) begin
    done_mac <= 1'b0;
    c_11 <= $urandom(); c_12 <= $urandom(); c_21 <= $urandom(); c_22 <= $urandom();
    if (rst) begin
      mac_pend <= 1'b0;
    end else if (start_mac && mac_en) begin
      mac_pend <= 1'b1;
      mac_lat  <= 3'($urandom_range(1, 5));
      prod[0]  <= a_11 * b_11 + a_12 * b_21;
      prod[1]  <= a_11 * b_12 + a_12 * b_22;
      prod[2]  <= a_21 * b_11 + a_22 * b_21;
      prod[3]  <= a_21 * b_12 + a_22 * b_22;
    end else if (mac_pend) begin
      if (mac_lat == 3'd1) begin
        done_mac <= 1'b1;
        mac_pend <= 1'b0;
        c_11 <= prod[0]; c_12 <= prod[1]; c_21 <= prod[2]; c_22 <= prod[3];
      end else begin
        mac_lat <= mac_lat - 3'd1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] exp_q [$];
  logic [RAM_AW-1:0] exp_addr_q [$];

  int cyc = 0;
  int done_cnt, err_cnt, mac_cnt, wr_cnt, smac_cyc, err_cyc;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (start_mac) begin mac_cnt++; smac_cyc = cyc; end
      if (ram_we) begin
        wr_cnt++;
        check_eq("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check_eq("wr_addr", 64'(ram_addr), 64'(exp_addr_q.pop_front()));
          check_eq("wr_data", 64'(ram_w_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem();
    for (int a = 0; a < RAM_D; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
  endtask

  task automatic set_hdr(input int m1, input int n1, input int m2, input int n2);
    mem[HDR_BASE] = {8'(m1), 8'(n1), 8'(m2), 8'(n2)};
  endtask

  // Reference C = A x B in row-major write order of 2x2 blocks.
  task automatic expect_product(input int m1, input int n1, input int n2);
    int bb, cb, r, c;
    logic [31:0] s;
    bb = A_BASE + m1 * n1;
    cb = bb + n1 * n2;
    for (int bi = 0; bi < (m1 + 1) / 2; bi++)
      for (int bj = 0; bj < (n2 + 1) / 2; bj++)
        for (int e = 0; e < 4; e++) begin
          r = 2 * bi + e / 2;
          c = 2 * bj + e % 2;
          if (r < m1 && c < n2) begin
            s = '0;
            for (int t = 0; t < n1; t++) s = s + mem[A_BASE + r * n1 + t] * mem[bb + t * n2 + c];
            exp_q.push_back(s);
            exp_addr_q.push_back(RAM_AW'(cb + r * n2 + c));
          end
        end
  endtask

  task automatic clear_counts();
    done_cnt = 0; err_cnt = 0; mac_cnt = 0; wr_cnt = 0;
  endtask

  task automatic run_op(input int budget);
    bit fin;
    clear_counts();
    @(negedge clk); start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk); #1;
      if (done_cnt + err_cnt > 0) fin = 1'b1;
    end
    check_eq("op_finished", 64'(fin), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("busy_idle", 64'(busy), 64'd0);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_ok(input string tag, input int macs, input int writes);
    check_eq({tag, "_done"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_err"}, 64'(err_cnt), 64'd0);
    check_eq({tag, "_code"}, 64'(err_code), 64'(ERR_NONE));
    if (macs >= 0) check_eq({tag, "_macs"}, 64'(mac_cnt), 64'(macs));
    check_eq({tag, "_writes"}, 64'(wr_cnt), 64'(writes));
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check_eq({tag, "_err"}, 64'(err_cnt), 64'd1);
    check_eq({tag, "_done"}, 64'(done_cnt), 64'd0);
    check_eq({tag, "_code"}, 64'(err_code), 64'(code));
    check_eq({tag, "_writes"}, 64'(wr_cnt), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit fin;
    clear_counts();
    fill_mem();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_we", 64'(ram_we), 64'd0);
    check_eq("rst_start_mac", 64'(start_mac), 64'd0);
    check_eq("rst_code", 64'(err_code), 64'd0);
    check_eq("rst_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_wdata", 64'(ram_w_data), 64'd0);
    check_eq("rst_a11", 64'(a_11), 64'd0);
    check_eq("rst_b22", 64'(b_22), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    // 2x2 * 2x2
    fill_mem(); set_hdr(2, 2, 2, 2);
    for (int x = 0; x < 4; x++) mem[2 + x] = 32'(x + 1);
    for (int x = 0; x < 4; x++) mem[6 + x] = 32'(x + 5);
    expect_product(2, 2, 2);
    run_op(400);
    expect_ok("t2x2", 1, 4);
    check_eq("t2x2_c11", 64'(mem[10]), 64'd19);
    check_eq("t2x2_c12", 64'(mem[11]), 64'd22);
    check_eq("t2x2_c21", 64'(mem[12]), 64'd43);
    check_eq("t2x2_c22", 64'(mem[13]), 64'd50);

    // 3x3 * 3x1, padding on every edge
    fill_mem(); set_hdr(3, 3, 3, 1);
    for (int x = 0; x < 9; x++) mem[2 + x] = 32'(x + 1);
    for (int x = 0; x < 3; x++) mem[11 + x] = 32'd1;
    expect_product(3, 3, 1);
    run_op(600);
    expect_ok("t3x3", 4, 3);
    check_eq("t3x3_c0", 64'(mem[14]), 64'd6);
    check_eq("t3x3_c1", 64'(mem[15]), 64'd15);
    check_eq("t3x3_c2", 64'(mem[16]), 64'd24);
    check_eq("t3x3_guard", 64'(mem[17]), 64'hC0DE_0011);

    // 1x1 * 1x1
    fill_mem(); set_hdr(1, 1, 1, 1);
    mem[2] = 32'd7; mem[3] = 32'd9;
    expect_product(1, 1, 1);
    run_op(200);
    expect_ok("t1x1", 1, 1);
    check_eq("t1x1_c", 64'(mem[4]), 64'd63);
    check_eq("t1x1_guard", 64'(mem[5]), 64'hC0DE_0005);

    // Wrap: 2x4 * 4x2 with stacked identity B
    fill_mem(); set_hdr(2, 4, 4, 2);
    mem[2] = 32'hFFFF_FFFF; mem[3] = 32'd1; mem[4] = 32'hFFFF_FFFF; mem[5] = 32'd7;
    for (int x = 6; x < 10; x++) mem[x] = $urandom();
    mem[10] = 32'd1; mem[11] = 32'd0; mem[12] = 32'd0; mem[13] = 32'd1;
    mem[14] = 32'd1; mem[15] = 32'd0; mem[16] = 32'd0; mem[17] = 32'd1;
    expect_product(2, 4, 2);
    run_op(400);
    expect_ok("twrap", 2, 4);
    check_eq("twrap_c11", 64'(mem[18]), 64'hFFFF_FFFE);
    check_eq("twrap_c12", 64'(mem[19]), 64'd8);

    // C exactly reaching the end of RAM: 1x6 * 6x72 (2+6+432+72 = 512)
    fill_mem(); set_hdr(1, 6, 6, 72);
    for (int x = 2; x < 440; x++) mem[x] = 32'($urandom_range(0, 1000));
    expect_product(1, 6, 72);
    run_op(6000);
    expect_ok("tfull", 108, 72);

    // Error paths
    fill_mem(); set_hdr(2, 3, 2, 2);
    run_op(100);
    expect_err("tmismatch", ERR_DIM_MISMATCH);
    check_eq("tmismatch_macs", 64'(mac_cnt), 64'd0);

    fill_mem(); set_hdr(0, 2, 2, 2);
    run_op(100);
    expect_err("tzero", ERR_BAD_SIZE);

    fill_mem(); set_hdr(1, 6, 6, 73);
    run_op(100);
    expect_err("toverflow", ERR_BAD_SIZE);

    fill_mem(); set_hdr(2, 3, 2, 0);
    run_op(100);
    expect_err("tzero_vs_mismatch", ERR_BAD_SIZE);

    // MAC timeout
    fill_mem(); set_hdr(2, 2, 2, 2);
    mac_en = 1'b0;
    run_op(200);
    expect_err("ttmo", ERR_MAC_TMO);
    check_eq("ttmo_macs", 64'(mac_cnt), 64'd1);
    check_eq("ttmo_latency", 64'(err_cyc - smac_cyc), 64'(MAC_TMO));
    mac_en = 1'b1;

    // Reset during MAC_WAIT, then a clean second run
    fill_mem(); set_hdr(2, 2, 2, 2);
    clear_counts();
    @(negedge clk); start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk); #1;
      if (dbg_state == 4'(MAC_WAIT)) fin = 1'b1;
    end
    check_eq("trst_reached_wait", 64'(fin), 64'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check_eq("trst_state", 64'(dbg_state), 64'(IDLE));
    check_eq("trst_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    #1;
    check_eq("trst_no_done", 64'(done_cnt), 64'd0);
    check_eq("trst_no_err", 64'(err_cnt), 64'd0);
    check_eq("trst_no_write", 64'(wr_cnt), 64'd0);

    for (int x = 2; x < 10; x++) mem[x] = $urandom();
    expect_product(2, 2, 2);
    run_op(400);
    expect_ok("trerun", 1, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
